ula_stack_sequencer: RTL
========================

Name: ula_stack_sequencer

Overview:
- Sequences the combinational ULA for the stack-based processor core.
- Accepts one instruction at a time (opcode + 16-bit immediate) from the control unit.
- Pops operands from an internal operand stack, drives the ULA and pushes the result back.
- Reports branch conditions, completion and stack/divide errors to the control unit.

Parameters:
- DEPTH, 8, operand stack entries (2..16).
- SP_W, 4, stack count width; must hold values 0..DEPTH.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer idle; instruction accepted when instr_valid and instr_ready are both high.
- instr_opcode  in  5  ULA opcode encoding.
- instr_imm  in  16  immediate, used by Push only.
- alu_operando1  out  16  ULA operand 1 (registered).
- alu_operando2  out  16  ULA operand 2 (registered).
- alu_opcode  out  5  ULA opcode (registered).
- alu_resultado  in  32  ULA result.
- alu_data_uc  in  1  ULA condition flag.
- done  out  1  one-cycle pulse when an instruction retires.
- branch_taken  out  1  valid with done; captured alu_data_uc for If_* opcodes, else 0.
- tos  out  16  current top of stack; 0 when the stack is empty.
- depth_count  out  SP_W  number of valid stack entries.
- last_result  out  32  full 32-bit ULA result of the last retired ALU instruction.
- err_underflow  out  1  sticky; set when an instruction needs more entries than are present.
- err_overflow  out  1  sticky; set on a push into a full stack.
- err_div0  out  1  sticky; set on Div with operando2 equal to 0.

Behaviour:
- Reset: state IDLE, depth_count=0, all stack entries=0, every output 0 except instr_ready=1. Reset mid-instruction abandons it; no done pulse.
- Opcode classes:
  - Push 00010: pops 0, pushes 1; operando1=imm.
  - Binary 00100..01100 (Add, Sub, Mul, Div, And, Nand, Or, Xor, Cmp): pops 2; operando1 = entry below top (NOS), operando2 = TOS; pushes 1.
  - Not 01101: pops 1 (operando1=TOS), pushes 1.
  - If_* 01111..10011: pops 1 (operando1=TOS), pushes 0.
  - Any other opcode: NOP. Retires with done and changes no state.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE. instr_valid is ignored in every other state.
- IDLE, on accept:
  - latch opcode and imm;
  - check underflow (depth_count < pops) and overflow (depth_count - pops + pushes > DEPTH);
  - on either error: set the sticky flag, discard the instruction, stack unchanged, pulse done with branch_taken=0 next cycle, return to IDLE.
- READ: load alu_operando1/2 and alu_opcode registers; decrement depth_count by the pop count. Unused operand registers are driven to 0.
- EXEC: the registered ULA inputs are stable; capture alu_resultado into last_result and alu_data_uc at end of cycle.
- WB:
  - push last_result[15:0] when pushes=1. Cmp -1 is pushed as 16'hFFFF; Mul upper bits are visible only in last_result.
  - pulse done; branch_taken=captured flag for If_* opcodes, else 0.
- Latency: done is high exactly 3 cycles after the accept cycle. Throughput: one instruction per 4 cycles.
- Div with operando2=0: set err_div0, push 16'h0000 instead of the ULA result; last_result=0.
- Stack: LIFO register array. Push writes index depth_count, then increments. depth_count never wraps.
- Sticky error flags clear only on reset.

Test Plan:
- Push 5, Push 3, Sub -> done at cycle accept+3 for each; final tos=2, depth_count=1, last_result=32'h2.
- Push 16'h0200, Push 16'h0300, Mul -> tos=16'h0000, last_result=32'h00060000, no error flags.
- Push 3, Push 5, Cmp -> tos=16'hFFFF. Then If_eq with tos=0 (after Push 0) -> done with branch_taken=1, depth_count decremented by 1.
- Empty stack, Add -> err_underflow=1, done one cycle after accept, depth_count=0. Then DEPTH pushes, then an extra Push -> err_overflow=1, tos unchanged.
- Push 7, Push 0, Div -> err_div0=1, tos=0, depth_count=1.
- Assert reset in EXEC of an Add -> next cycle state IDLE, instr_ready=1, depth_count=0, no done pulse. Also hold instr_valid high during a busy instruction -> no second accept until IDLE.

Source files
------------

// File: rtl/ula_stack_sequencer.sv
// rtl/ula_stack_sequencer.sv - operand-stack sequencer driving the combinational ULA
module ula_stack_sequencer #(
    parameter int DEPTH = 8,
    parameter int SP_W  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [4:0]      instr_opcode,
    input  logic [15:0]     instr_imm,
    output logic [15:0]     alu_operando1,
    output logic [15:0]     alu_operando2,
    output logic [4:0]      alu_opcode,
    input  logic [31:0]     alu_resultado,
    input  logic            alu_data_uc,
    output logic            done,
    output logic            branch_taken,
    output logic [15:0]     tos,
    output logic [SP_W-1:0] depth_count,
    output logic [31:0]     last_result,
    output logic            err_underflow,
    output logic            err_overflow,
    output logic            err_div0
);

    localparam logic [4:0] OP_PUSH = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    function automatic logic is_binary(input logic [4:0] op);
        return (op >= 5'b00100) && (op <= 5'b01100);
    endfunction

    function automatic logic is_if(input logic [4:0] op);
        return (op >= 5'b01111) && (op <= 5'b10011);
    endfunction

    // Instructions that actually consume a ULA result (Push and NOP do not).
    function automatic logic is_alu(input logic [4:0] op);
        return is_binary(op) || (op == OP_NOT) || is_if(op);
    endfunction

    function automatic logic [1:0] pops_of(input logic [4:0] op);
        if (is_binary(op))                   return 2'd2;
        else if ((op == OP_NOT) || is_if(op)) return 2'd1;
        else                                  return 2'd0;
    endfunction

    function automatic logic pushes_of(input logic [4:0] op);
        return (op == OP_PUSH) || is_binary(op) || (op == OP_NOT);
    endfunction

    state_t          state_q, state_d;
    logic [4:0]      op_q;
    logic [15:0]     imm_q;
    logic [SP_W-1:0] depth_q;
    logic [15:0]     stack_q [DEPTH];
    logic [15:0]     opnd1_q, opnd2_q;
    logic [4:0]      aluop_q;
    logic [31:0]     result_q;
    logic            flag_q;
    logic            err_underflow_q, err_overflow_q, err_div0_q;

    logic [15:0]     tos_val, nos_val;
    logic            acc_under, acc_over;

    // Top and next-on-stack read ports, selected by the current entry count.
    always_comb begin
        tos_val = '0;
        nos_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(depth_q) == i + 1) tos_val = stack_q[i];
            if (int'(depth_q) == i + 2) nos_val = stack_q[i];
        end
    end

    // Stack bounds check for the instruction being offered at the input.
    always_comb begin
        acc_under = int'(depth_q) < int'(pops_of(instr_opcode));
        acc_over  = (int'(depth_q) - int'(pops_of(instr_opcode))
                     + int'(pushes_of(instr_opcode))) > DEPTH;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; rejected instructions take the one-cycle ERR path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = (acc_under || acc_over) ? S_ERR : S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch, operand fetch/pop, result capture, push-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q            <= '0;
            imm_q           <= '0;
            depth_q         <= '0;
            opnd1_q         <= '0;
            opnd2_q         <= '0;
            aluop_q         <= '0;
            result_q        <= '0;
            flag_q          <= 1'b0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_div0_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_opcode;
                        imm_q <= instr_imm;
                        if (acc_under)     err_underflow_q <= 1'b1;
                        else if (acc_over) err_overflow_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (op_q == OP_PUSH) begin
                        opnd1_q <= imm_q;
                        opnd2_q <= '0;
                        aluop_q <= op_q;
                    end else if (is_binary(op_q)) begin
                        opnd1_q <= nos_val;
                        opnd2_q <= tos_val;
                        aluop_q <= op_q;
                    end else if (is_alu(op_q)) begin
                        opnd1_q <= tos_val;
                        opnd2_q <= '0;
                        aluop_q <= op_q;
                    end
                    depth_q <= depth_q - SP_W'(pops_of(op_q));
                end
                S_EXEC: begin
                    if (is_alu(op_q)) begin
                        if ((op_q == OP_DIV) && (opnd2_q == 16'h0000)) begin
                            result_q   <= '0;
                            flag_q     <= 1'b0;
                            err_div0_q <= 1'b1;
                        end else begin
                            result_q <= alu_resultado;
                            flag_q   <= alu_data_uc;
                        end
                    end
                end
                S_WB: begin
                    if (pushes_of(op_q)) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (int'(depth_q) == i)
                                stack_q[i] <= (op_q == OP_PUSH) ? imm_q : result_q[15:0];
                        end
                        depth_q <= depth_q + SP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready   = (state_q == S_IDLE);
    assign done          = (state_q == S_WB) || (state_q == S_ERR);
    assign branch_taken  = (state_q == S_WB) && is_if(op_q) && flag_q;
    assign alu_operando1 = opnd1_q;
    assign alu_operando2 = opnd2_q;
    assign alu_opcode    = aluop_q;
    assign tos           = tos_val;
    assign depth_count   = depth_q;
    assign last_result   = result_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign err_div0      = err_div0_q;

endmodule
